mask_centroid: RTL and testbench

- Consumes the filtered binary skin mask and its de/vsync stream from the 5x5 median stage.
- Per frame, accumulates masked-pixel count, coordinate sums and bounding box.
- At each frame boundary, snapshots the accumulators and runs a serial divider to produce the centroid.
- Results feed the downstream hand-tracking/overlay logic once per frame.

---
 rtl/mask_centroid.sv | 164 ++++++++++++++++
 tb/tb_mask_centroid.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mask_centroid.sv
// mask_centroid: per-frame skin-mask count, bounding box and centroid via serial restoring division.
module mask_centroid #(
  parameter int H_SIZE = 64,
  parameter int V_SIZE = 48,
  parameter int CNT_W  = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             mask,
  input  logic             in_de,
  input  logic             in_vsync,
  output logic [9:0]       out_cx,
  output logic [9:0]       out_cy,
  output logic [CNT_W-1:0] out_count,
  output logic [9:0]       out_xmin,
  output logic [9:0]       out_xmax,
  output logic [9:0]       out_ymin,
  output logic [9:0]       out_ymax,
  output logic             out_valid,
  output logic             out_empty,
  output logic             out_drop,
  output logic             busy
);
  localparam int SW = CNT_W + 10;
  if (H_SIZE * V_SIZE >= (1 << CNT_W)) begin : g_cnt_w_check
    $error("CNT_W too small for H_SIZE*V_SIZE");
  end
  typedef enum logic [2:0] {IDLE, CHECK, DIV_X, DIV_Y, DONE} state_t;
  state_t state;
  logic [9:0] x, y, xmin, xmax, ymin, ymax;
  logic [9:0] xmin_n, xmax_n, ymin_n, ymax_n;
  logic [9:0] s_xmin, s_xmax, s_ymin, s_ymax;
  logic de_d, vs_d, pix, fe, ge, empty, fin;
  logic [CNT_W-1:0] cnt, cnt_n, s_cnt, rem, rem_n;
  logic [SW-1:0] sx, sy, sx_n, sy_n, s_sx, s_sy;
  logic [CNT_W:0] trial;
  logic [9:0] dq, q_n, qx;
  logic [3:0] k;
  always_comb begin
    pix    = ce & in_de & mask;
    fe     = ce & in_vsync & ~vs_d;
    cnt_n  = cnt + CNT_W'(pix);
    sx_n   = pix ? sx + SW'(x) : sx;
    sy_n   = pix ? sy + SW'(y) : sy;
    xmin_n = (pix && x < xmin) ? x : xmin;
    xmax_n = (pix && x > xmax) ? x : xmax;
    ymin_n = (pix && y < ymin) ? y : ymin;
    ymax_n = (pix && y > ymax) ? y : ymax;
    trial  = {rem, dq[9]};
    ge     = trial >= {1'b0, s_cnt};
    rem_n  = CNT_W'(ge ? trial - {1'b0, s_cnt} : trial);
    q_n    = {dq[8:0], ge};
    empty  = s_cnt == '0;
    fin    = (state == CHECK && empty) || (state == DIV_Y && k == 4'd9);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      de_d <= 1'b0;
      vs_d <= 1'b0;
      cnt  <= '0;
      sx   <= '0;
      sy   <= '0;
      xmin <= 10'h3ff;
      xmax <= '0;
      ymin <= 10'h3ff;
      ymax <= '0;
    end else if (ce) begin
      de_d <= in_de;
      vs_d <= in_vsync;
      x    <= (fe || (!in_de && de_d)) ? '0 : (in_de && x != 10'h3ff) ? x + 10'd1 : x;
      y    <= fe ? '0 : (!in_de && de_d && y != 10'h3ff) ? y + 10'd1 : y;
      cnt  <= fe ? '0 : cnt_n;
      sx   <= fe ? '0 : sx_n;
      sy   <= fe ? '0 : sy_n;
      xmin <= fe ? 10'h3ff : xmin_n;
      xmax <= fe ? '0 : xmax_n;
      ymin <= fe ? 10'h3ff : ymin_n;
      ymax <= fe ? '0 : ymax_n;
    end
  end
  // Remainder starts as dividend>>10; the low 10 dividend bits shift out of dq as quotient bits shift in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_empty <= 1'b0;
      out_drop  <= 1'b0;
      out_cx    <= '0;
      out_cy    <= '0;
      out_count <= '0;
      out_xmin  <= '0;
      out_xmax  <= '0;
      out_ymin  <= '0;
      out_ymax  <= '0;
      s_cnt     <= '0;
      s_sx      <= '0;
      s_sy      <= '0;
      s_xmin    <= '0;
      s_xmax    <= '0;
      s_ymin    <= '0;
      s_ymax    <= '0;
      rem       <= '0;
      dq        <= '0;
      qx        <= '0;
      k         <= '0;
    end else begin
      out_valid <= fin;
      out_drop  <= fe && state != IDLE;
      if (fin) begin
        out_cx    <= empty ? '0 : qx;
        out_cy    <= empty ? '0 : q_n;
        out_count <= s_cnt;
        out_xmin  <= empty ? '0 : s_xmin;
        out_xmax  <= empty ? '0 : s_xmax;
        out_ymin  <= empty ? '0 : s_ymin;
        out_ymax  <= empty ? '0 : s_ymax;
        out_empty <= empty;
      end
      case (state)
        IDLE: if (fe) begin
          state  <= CHECK;
          busy   <= 1'b1;
          s_cnt  <= cnt_n;
          s_sx   <= sx_n;
          s_sy   <= sy_n;
          s_xmin <= xmin_n;
          s_xmax <= xmax_n;
          s_ymin <= ymin_n;
          s_ymax <= ymax_n;
        end
        CHECK: begin
          state <= empty ? DONE : DIV_X;
          rem   <= s_sx[SW-1:10];
          dq    <= s_sx[9:0];
          k     <= '0;
        end
        DIV_X: begin
          rem <= k == 4'd9 ? s_sy[SW-1:10] : rem_n;
          dq  <= k == 4'd9 ? s_sy[9:0] : q_n;
          k   <= k == 4'd9 ? '0 : k + 4'd1;
          if (k == 4'd9) begin
            qx    <= q_n;
            state <= DIV_Y;
          end
        end
        DIV_Y: begin
          rem <= rem_n;
          dq  <= q_n;
          k   <= k + 4'd1;
          if (k == 4'd9) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mask_centroid.sv
// tb_mask_centroid: directed frames on an 8x4 image with hand-computed centroid and bbox results.
module tb_mask_centroid;
  localparam int H = 8;
  localparam int V = 4;
  localparam int CW = 20;
  logic clk = 1'b0, rst_n = 1'b0, ce = 1'b0, mask = 1'b0, in_de = 1'b0, in_vsync = 1'b0;
  logic [9:0] out_cx, out_cy, out_xmin, out_xmax, out_ymin, out_ymax;
  logic [CW-1:0] out_count;
  logic out_valid, out_empty, out_drop, busy;
  int n_cmp = 0, n_err = 0, cyc = 0, drops = 0, t0 = 0, vcnt = 0;
  mask_centroid #(.H_SIZE(H), .V_SIZE(V), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .mask(mask), .in_de(in_de), .in_vsync(in_vsync),
    .out_cx(out_cx), .out_cy(out_cy), .out_count(out_count),
    .out_xmin(out_xmin), .out_xmax(out_xmax), .out_ymin(out_ymin), .out_ymax(out_ymax),
    .out_valid(out_valid), .out_empty(out_empty), .out_drop(out_drop), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic pix(input logic c, input logic d, input logic m, input logic v);
    ce = c;
    in_de = d;
    mask = m;
    in_vsync = v;
    @(posedge clk);
    #1;
    cyc++;
    if (out_drop) drops++;
  endtask
  task automatic line(input logic [7:0] r);
    for (int i = 0; i < H; i++) pix(1'b1, 1'b1, r[i], 1'b0);
    pix(1'b1, 1'b0, 1'b0, 1'b0);
    pix(1'b1, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic frame(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2, input logic [7:0] r3);
    line(r0);
    line(r1);
    line(r2);
    line(r3);
  endtask
  task automatic wait_valid(input string tag, input int lat);
    while (!out_valid && cyc - t0 < 40) pix(1'b1, 1'b0, 1'b0, cyc - t0 < 3);
    chk({tag, "_lat"}, cyc - t0, lat);
  endtask
  task automatic end_frame(input string tag, input int lat);
    drops = 0;
    pix(1'b1, 1'b0, 1'b0, 1'b1);
    t0 = cyc;
    chk({tag, "_busy"}, busy, 1);
    wait_valid(tag, lat);
    chk({tag, "_drop"}, drops, 0);
  endtask
  task automatic res(input string tag, input int cx, input int cy, input int n, input int x0,
                     input int x1, input int y0, input int y1, input int e);
    chk({tag, "_cx"}, out_cx, cx);
    chk({tag, "_cy"}, out_cy, cy);
    chk({tag, "_count"}, out_count, n);
    chk({tag, "_xmin"}, out_xmin, x0);
    chk({tag, "_xmax"}, out_xmax, x1);
    chk({tag, "_ymin"}, out_ymin, y0);
    chk({tag, "_ymax"}, out_ymax, y1);
    chk({tag, "_empty"}, out_empty, e);
  endtask
  task automatic idle_count(input int n);
    vcnt = 0;
    for (int i = 0; i < n; i++) begin
      pix(1'b1, 1'b0, 1'b0, 1'b0);
      if (out_valid) vcnt++;
    end
  endtask
  initial begin
    #12;
    res("rst", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    pix(1'b1, 1'b0, 1'b0, 1'b0);
    frame(8'h00, 8'h00, 8'h08, 8'h00);
    end_frame("single", 21);
    res("single", 3, 2, 1, 3, 3, 2, 2, 0);
    pix(1'b1, 1'b0, 1'b0, 1'b0);
    chk("single_pulse", out_valid, 0);
    frame(8'h00, 8'h30, 8'h30, 8'h00);
    end_frame("block", 21);
    res("block", 4, 1, 4, 4, 5, 1, 2, 0);
    frame(8'h00, 8'h00, 8'h00, 8'h00);
    drops = 0;
    pix(1'b1, 1'b0, 1'b0, 1'b1);
    chk("empty_busy0", busy, 1);
    chk("empty_valid0", out_valid, 0);
    pix(1'b1, 1'b0, 1'b0, 1'b1);
    chk("empty_busy1", busy, 1);
    chk("empty_valid1", out_valid, 1);
    res("empty", 0, 0, 0, 0, 0, 0, 0, 1);
    pix(1'b1, 1'b0, 1'b0, 1'b1);
    chk("empty_busy2", busy, 0);
    chk("empty_valid2", out_valid, 0);
    pix(1'b1, 1'b0, 1'b0, 1'b0);
    chk("empty_drop", drops, 0);
    frame(8'h00, 8'h04, 8'h00, 8'h40);
    drops = 0;
    pix(1'b1, 1'b0, 1'b0, 1'b1);
    t0 = cyc;
    for (int i = 0; i < 3; i++) pix(1'b1, 1'b1, 1'b1, 1'b0);
    pix(1'b1, 1'b0, 1'b0, 1'b0);
    pix(1'b1, 1'b0, 1'b0, 1'b1);
    chk("drop_pulse", out_drop, 1);
    pix(1'b1, 1'b0, 1'b0, 1'b0);
    chk("drop_clear", out_drop, 0);
    wait_valid("drop", 21);
    res("drop", 4, 2, 2, 2, 6, 1, 3, 0);
    idle_count(30);
    chk("drop_no_second", vcnt, 0);
    chk("drop_count", drops, 1);
    frame(8'h20, 8'h00, 8'h00, 8'h00);
    end_frame("after_drop", 21);
    res("after_drop", 5, 0, 1, 5, 5, 0, 0, 0);
    frame(8'h00, 8'h00, 8'h00, 8'h04);
    pix(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) pix(1'b1, 1'b0, 1'b0, 1'b0);
    chk("abort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    res("abort", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("abort_busy0", busy, 0);
    #1;
    rst_n = 1'b1;
    idle_count(30);
    chk("abort_no_valid", vcnt, 0);
    frame(8'h00, 8'h02, 8'h00, 8'h00);
    end_frame("post_rst", 21);
    res("post_rst", 1, 1, 1, 1, 1, 1, 1, 0);
    pix(1'b1, 1'b1, 1'b0, 1'b0);
    pix(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) pix(1'b0, 1'b1, 1'b1, 1'b0);
    pix(1'b1, 1'b1, 1'b1, 1'b0);
    pix(1'b1, 1'b1, 1'b0, 1'b0);
    pix(1'b0, 1'b1, 1'b1, 1'b0);
    pix(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) pix(1'b1, 1'b1, 1'b0, 1'b0);
    pix(1'b1, 1'b0, 1'b0, 1'b0);
    pix(1'b1, 1'b0, 1'b0, 1'b0);
    end_frame("ce", 21);
    res("ce", 3, 0, 2, 2, 4, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
